branch_unit_bht: RTL

//  Parametrised branch resolution + direction prediction unit for the RV32I core.
//  EX stage: compares rs1/rs2 directly (full signed/unsigned) for all six conditional

---
 rtl/branch_unit_bht_if.sv | 51 +++++
 rtl/branch_unit_bht.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_unit_bht_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_unit_bht_if
//  Description : Bundle of fetch-prediction, execute-resolve and redirect /
//                statistics signals between the core pipeline (master) and
//                the branch unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_unit_bht_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 16
);
    // Fetch-side prediction lookup
    logic [XLEN-1:0]   if_pc;
    logic              if_pred_taken;

    // Execute-side resolve request
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_jal;
    logic              ex_jalr;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1;
    logic [XLEN-1:0]   ex_rs2;
    logic [XLEN-1:0]   ex_imm;
    logic              ex_pred_taken;

    // Redirect and performance counters
    logic              flush;
    logic [XLEN-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output if_pc,
        output ex_valid, ex_branch, ex_jal, ex_jalr, ex_funct3,
        output ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
        input  if_pred_taken,
        input  flush, redirect_pc, stat_branches, stat_mispred
    );

    modport slave (
        input  if_pc,
        input  ex_valid, ex_branch, ex_jal, ex_jalr, ex_funct3,
        input  ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
        output if_pred_taken,
        output flush, redirect_pc, stat_branches, stat_mispred
    );
endinterface
`default_nettype wire

// File: rtl/branch_unit_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_unit_bht
//  Description : RV32I branch resolution and direction prediction. Resolves
//                conditional branches and jal/jalr in EX, registers a single
//                cycle flush/redirect on mispredict or jump, and keeps a table
//                of saturating counters that drives the fetch-stage prediction.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_unit_bht #(
    parameter int XLEN     = 32,
    parameter int BHT_IDX  = 6,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    branch_unit_bht_if.slave    bht_if
);

    localparam int                 ENTRIES  = 1 << BHT_IDX;
    localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0]   STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0]   STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_upd_d;
    logic                flush_q,        flush_d;
    logic [XLEN-1:0]     redirect_pc_q,  redirect_pc_d;
    logic [STAT_W-1:0]   stat_br_q,      stat_br_d;
    logic [STAT_W-1:0]   stat_mp_q,      stat_mp_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [BHT_IDX-1:0]  w_if_idx;
    logic [BHT_IDX-1:0]  w_ex_idx;
    logic [CNT_BITS-1:0] w_cnt_cur;
    logic                w_eq;
    logic                w_lt;
    logic                w_ltu;
    logic                w_cond_ok;
    logic                w_cond_taken;
    logic                w_is_jump;
    logic                w_is_cond;
    logic                w_mispred;
    logic [XLEN-1:0]     w_pc_plus_imm;
    logic [XLEN-1:0]     w_pc_plus_4;
    logic [XLEN-1:0]     w_jalr_sum;
    logic [XLEN-1:0]     w_jump_tgt;
    logic [XLEN-1:0]     w_next_pc;
    logic                w_unused;

    // Only the word-index bits of the fetch PC select a counter.
    assign w_if_idx = bht_if.if_pc[BHT_IDX+1:2];
    assign w_ex_idx = bht_if.ex_pc[BHT_IDX+1:2];
    assign w_unused = ^{bht_if.if_pc[1:0], bht_if.if_pc[XLEN-1:BHT_IDX+2]};

    // Prediction reads the stored counter directly; an update landing on the
    // same index this cycle becomes visible only after the clock edge.
    assign bht_if.if_pred_taken = cnt_q[w_if_idx][CNT_BITS-1];

    assign w_eq  = (bht_if.ex_rs1 == bht_if.ex_rs2);
    assign w_lt  = ($signed(bht_if.ex_rs1) < $signed(bht_if.ex_rs2));
    assign w_ltu = (bht_if.ex_rs1 < bht_if.ex_rs2);

    // Decode the branch condition; reserved encodings never take and never train.
    always_comb begin
        w_cond_ok    = 1'b1;
        w_cond_taken = 1'b0;
        case (bht_if.ex_funct3)
            F3_BEQ:  w_cond_taken = w_eq;
            F3_BNE:  w_cond_taken = ~w_eq;
            F3_BLT:  w_cond_taken = w_lt;
            F3_BGE:  w_cond_taken = ~w_lt;
            F3_BLTU: w_cond_taken = w_ltu;
            F3_BGEU: w_cond_taken = ~w_ltu;
            default: w_cond_ok    = 1'b0;
        endcase
    end

    // Jumps win over a simultaneously flagged conditional branch.
    assign w_is_jump = bht_if.ex_jal | bht_if.ex_jalr;
    assign w_is_cond = bht_if.ex_valid & bht_if.ex_branch & ~w_is_jump & w_cond_ok;
    assign w_mispred = w_is_cond & (w_cond_taken != bht_if.ex_pred_taken);

    assign w_pc_plus_imm = bht_if.ex_pc + bht_if.ex_imm;
    assign w_pc_plus_4   = bht_if.ex_pc + XLEN'(4);
    assign w_jalr_sum    = bht_if.ex_rs1 + bht_if.ex_imm;
    assign w_jump_tgt    = bht_if.ex_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_plus_imm;

    // Resolve the true next PC and decide whether fetch must be redirected.
    // With no target buffer every valid jump redirects.
    always_comb begin
        if (w_is_jump) begin
            w_next_pc = w_jump_tgt;
        end else if (w_cond_taken) begin
            w_next_pc = w_pc_plus_imm;
        end else begin
            w_next_pc = w_pc_plus_4;
        end
        flush_d       = (bht_if.ex_valid & w_is_jump) | w_mispred;
        redirect_pc_d = flush_d ? w_next_pc : '0;
    end

    // Saturating train value for the counter of the resolving branch.
    always_comb begin
        w_cnt_cur = cnt_q[w_ex_idx];
        cnt_upd_d = w_cnt_cur;
        if (w_cond_taken) begin
            if (w_cnt_cur != CNT_MAX) begin
                cnt_upd_d = w_cnt_cur + CNT_ONE;
            end
        end else begin
            if (w_cnt_cur != '0) begin
                cnt_upd_d = w_cnt_cur - CNT_ONE;
            end
        end
    end

    // Performance counters stick at their maximum instead of wrapping.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (w_is_cond && (stat_br_q != STAT_MAX)) begin
            stat_br_d = stat_br_q + STAT_ONE;
        end
        if (w_mispred && (stat_mp_q != STAT_MAX)) begin
            stat_mp_d = stat_mp_q + STAT_ONE;
        end
    end

    // Counter table: reset to weakly not-taken, trained by valid conditional branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (w_is_cond) begin
            cnt_q[w_ex_idx] <= cnt_upd_d;
        end
    end

    // Redirect and statistics registers; reset also discards a pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            stat_br_q     <= '0;
            stat_mp_q     <= '0;
        end else begin
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

    assign bht_if.flush         = flush_q;
    assign bht_if.redirect_pc   = redirect_pc_q;
    assign bht_if.stat_branches = stat_br_q;
    assign bht_if.stat_mispred  = stat_mp_q;

endmodule
`default_nettype wire
